tdm_demux: RTL and testbench

- Receive end of the team's time-division multiplexed link: the mux side places LANES words in turn on one bus, and this block steers each word back to its own lane.
- Tracks the slot position with a frame-sync marker and assembles a full frame in a shadow register.
- Presents the completed frame in parallel, with a one-cycle valid strobe.
- Sits between the serial TDM bus and lane-wise consumer logic.

---
 rtl/tdm_pkg.sv | 17 +
 rtl/tdm_slot_counter.sv | 41 ++++
 rtl/tdm_demux.sv | 108 ++++++++++
 tb/tb_tdm_demux.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM link: state encoding, default frame geometry
// and the slot-counter width helper used by both the mux and demux sides.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

    localparam int TDM_LANES = 4;
    localparam int TDM_WIDTH = 8;

    function automatic int slot_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Mod-LANES slot counter with priority clear > load-to-1 > increment.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int LANES = TDM_LANES,
    localparam int SW   = slot_width(LANES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          load1_i,
    input  logic          clr_i,
    output logic [SW-1:0] slot_o
);

    localparam logic [SW-1:0] LAST = SW'(LANES - 1);

    logic [SW-1:0] slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (clr_i) begin
            slot_d = '0;
        end else if (load1_i) begin
            slot_d = SW'(1);
        end else if (en_i) begin
            slot_d = (slot_q == LAST) ? '0 : slot_q + SW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux.sv
// TDM receive side: aligns to frame_sync, assembles each frame in a shadow
// register and publishes it in parallel with a one-cycle dout_valid strobe.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int LANES = TDM_LANES,
    parameter int WIDTH = TDM_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       din,
    input  logic                   din_valid,
    input  logic                   frame_sync,
    output logic [LANES*WIDTH-1:0] dout,
    output logic                   dout_valid,
    output logic                   locked,
    output logic                   sync_err,
    output tdm_state_e             dbg_state_o
);

    localparam int SW = slot_width(LANES);
    localparam logic [SW-1:0] LAST = SW'(LANES - 1);

    typedef logic [LANES-1:0][WIDTH-1:0] frame_t;

    tdm_state_e state_q, state_d;
    frame_t     shadow_q, shadow_d;
    frame_t     dout_q, dout_d;
    logic       dout_valid_q, dout_valid_d;
    logic       sync_err_q, sync_err_d;
    logic [SW-1:0] slot;
    logic       cnt_en, cnt_load1, cnt_clr;

    tdm_slot_counter #(.LANES(LANES)) u_slot (
        .clk     (clk),
        .rst     (rst),
        .en_i    (cnt_en),
        .load1_i (cnt_load1),
        .clr_i   (cnt_clr),
        .slot_o  (slot)
    );

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sync_err_d   = 1'b0;
        cnt_en       = 1'b0;
        cnt_load1    = 1'b0;
        cnt_clr      = 1'b0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_d[0] = din;
                        cnt_load1   = 1'b1;
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync && slot != '0) begin
                        // Early sync: drop the partial frame, restart at slot 0.
                        sync_err_d  = 1'b1;
                        shadow_d    = '0;
                        shadow_d[0] = din;
                        cnt_load1   = 1'b1;
                    end else if (!frame_sync && slot == '0) begin
                        sync_err_d = 1'b1;
                        cnt_clr    = 1'b1;
                        state_d    = HUNT;
                    end else begin
                        shadow_d[slot] = din;
                        cnt_en         = 1'b1;
                        if (slot == LAST) begin
                            dout_d       = shadow_d;
                            dout_valid_d = 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HUNT;
            shadow_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign sync_err    = sync_err_q;
    assign locked      = (state_q == LOCKED);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed frames plus randomized traffic checked
// against a frame-queue reference model.
module tb_tdm_demux;
    import tdm_pkg::*;

    localparam int LANES = 4;
    localparam int WIDTH = 8;
    localparam int FW    = LANES * WIDTH;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [WIDTH-1:0]       din = '0;
    logic                   din_valid = 1'b0;
    logic                   frame_sync = 1'b0;
    logic [FW-1:0]          dout;
    logic                   dout_valid;
    logic                   locked;
    logic                   sync_err;
    tdm_state_e             dbg_state_o;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: words collected since the last slot-0 word
    logic [WIDTH-1:0] cur[$];
    logic [FW-1:0]    exp_q[$];
    logic [FW-1:0]    m_dout;
    logic             m_dout_valid;
    logic             m_sync_err;
    logic             m_locked;

    tdm_demux #(.LANES(LANES), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .locked      (locked),
        .sync_err    (sync_err),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        cur.delete();
        exp_q.delete();
        m_dout       = '0;
        m_dout_valid = 1'b0;
        m_sync_err   = 1'b0;
        m_locked     = 1'b0;
    endtask

    task automatic model_step(input logic [WIDTH-1:0] d, input logic v, input logic s);
        logic [FW-1:0] f;
        m_dout_valid = 1'b0;
        m_sync_err   = 1'b0;
        if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_locked = 1'b1;
                    cur.delete();
                    cur.push_back(d);
                end
            end else if (s) begin
                if (cur.size() != 0) m_sync_err = 1'b1;
                cur.delete();
                cur.push_back(d);
            end else if (cur.size() == 0) begin
                m_sync_err = 1'b1;
                m_locked   = 1'b0;
            end else begin
                cur.push_back(d);
                if (cur.size() == LANES) begin
                    f = '0;
                    for (int i = 0; i < LANES; i++) f[i*WIDTH +: WIDTH] = cur[i];
                    m_dout       = f;
                    m_dout_valid = 1'b1;
                    exp_q.push_back(f);
                    cur.delete();
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("dout", dout, m_dout);
        check("dout_valid", dout_valid, m_dout_valid);
        check("sync_err", sync_err, m_sync_err);
        check("locked", locked, m_locked);
        check("state", dbg_state_o, m_locked);
        if (dout_valid && exp_q.size() > 0) check("sb_frame", dout, exp_q.pop_front());
    endtask

    task automatic drive(input logic [WIDTH-1:0] d, input logic v, input logic s);
        din        = d;
        din_valid  = v;
        frame_sync = s;
        @(posedge clk);
        model_step(d, v, s);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        int k;
        logic s;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;

        // clean frame
        drive(8'h11, 1, 1); drive(8'h22, 1, 0); drive(8'h33, 1, 0); drive(8'h44, 1, 0);
        check("tp_clean", dout, 32'h44332211);
        idle(1);

        // gapped frame
        drive(8'h11, 1, 1); drive(8'h22, 1, 0); idle(3);
        drive(8'h33, 1, 0); drive(8'h44, 1, 0);
        check("tp_gapped", dout, 32'h44332211);

        // data before sync (from HUNT: break lock first)
        drive(8'h99, 1, 0);
        drive(8'hAA, 1, 0); drive(8'hBB, 1, 0);
        drive(8'h01, 1, 1); drive(8'h02, 1, 0); drive(8'h03, 1, 0); drive(8'h04, 1, 0);
        check("tp_presync", dout, 32'h04030201);

        // early sync
        drive(8'h10, 1, 1); drive(8'h20, 1, 0); drive(8'h30, 1, 1);
        drive(8'h40, 1, 0); drive(8'h50, 1, 0); drive(8'h60, 1, 0);
        check("tp_early", dout, 32'h60504030);

        // sync at last slot: resync, no completion
        drive(8'h71, 1, 1); drive(8'h72, 1, 0); drive(8'h73, 1, 0); drive(8'h74, 1, 1);
        drive(8'h75, 1, 0); drive(8'h76, 1, 0); drive(8'h77, 1, 0);
        check("tp_lastsync", dout, 32'h77767574);

        // missing sync then relock
        drive(8'h01, 1, 1); drive(8'h02, 1, 0); drive(8'h03, 1, 0); drive(8'h04, 1, 0);
        drive(8'h05, 1, 0);
        check("tp_miss_lock", locked, 0);
        check("tp_miss_dout", dout, 32'h04030201);
        drive(8'hA1, 1, 1); drive(8'hA2, 1, 0); drive(8'hA3, 1, 0); drive(8'hA4, 1, 0);
        check("tp_relock", dout, 32'hA4A3A2A1);

        // async reset mid-frame
        drive(8'hC1, 1, 1); drive(8'hC2, 1, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        drive(8'hD1, 1, 1); drive(8'hD2, 1, 0); drive(8'hD3, 1, 0); drive(8'hD4, 1, 0);
        check("tp_after_rst", dout, 32'hD4D3D2D1);

        // randomized traffic, mostly aligned with occasional sync faults
        k = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                s = ((k % LANES) == 0) ^ ($urandom_range(0, 15) == 0);
                drive(8'($urandom_range(0, 255)), 1'b1, s);
                k++;
            end else begin
                drive(8'($urandom_range(0, 255)), 1'b0, 1'($urandom_range(0, 1)));
            end
        end

        check("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
